// File: rtl/fifo_serializer_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned width;
        int unsigned v;
        width = 0;
        if (value > 1) begin
            for (v = value - 1; v != 0; v = v >> 1) begin
                width = width + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period divider: counts while run is high and pulses tick on the wrap cycle.
module bit_period_counter
    import fifo_serializer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = clogb2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    // Held at zero while idle, so every word starts with a full first bit.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO read port and shifts them out MSB first, CLKS_PER_BIT clocks per bit.
module fifo_word_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ack,
    output logic                   serial_out,
    output logic                   serial_frame,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] words_sent
);

    localparam int unsigned BW = clogb2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_tick;

    // Gated by rst so nothing is popped (and lost) while reset is held.
    assign data_in_ack = !rst && (state == IDLE) && enable && data_in_valid;
    assign shifted     = shift_reg << 1;

    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_divider (
        .clock (clock),
        .rst   (rst),
        .run   (state == SHIFT),
        .tick  (bit_tick)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_frame <= 1'b0;
            busy         <= 1'b0;
            words_sent   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in_ack) begin
                        shift_reg    <= data_in;
                        bit_cnt      <= '0;
                        serial_out   <= data_in[DATA_WIDTH-1];
                        serial_frame <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        shift_reg <= shifted;
                        if (bit_cnt == LAST_BIT) begin
                            serial_out   <= 1'b0;
                            serial_frame <= 1'b0;
                            busy         <= 1'b0;
                            words_sent   <= words_sent + COUNT_WIDTH'(1);
                            state        <= IDLE;
                        end else begin
                            serial_out <= shifted[DATA_WIDTH-1];
                            bit_cnt    <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed self-checking bench for fifo_word_serializer (8-bit words).
module tb_fifo_word_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst;

    // dut_a: CLKS_PER_BIT=2; dut_b: COUNT_WIDTH=2; dut_c: CLKS_PER_BIT=1
    logic       en_a, valid_a, ack_a, so_a, fr_a, busy_a;
    logic [7:0] data_a;
    logic [15:0] ws_a;
    logic       en_b, valid_b, ack_b, so_b, fr_b, busy_b;
    logic [7:0] data_b;
    logic [1:0] ws_b;
    logic       en_c, valid_c, ack_c, so_c, fr_c, busy_c;
    logic [7:0] data_c;
    logic [15:0] ws_c;

    int total = 0;
    int bad   = 0;

    fifo_word_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .COUNT_WIDTH(16)) dut_a (
        .clock(clock), .rst(rst), .enable(en_a), .data_in(data_a), .data_in_valid(valid_a),
        .data_in_ack(ack_a), .serial_out(so_a), .serial_frame(fr_a), .busy(busy_a), .words_sent(ws_a)
    );

    fifo_word_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .COUNT_WIDTH(2)) dut_b (
        .clock(clock), .rst(rst), .enable(en_b), .data_in(data_b), .data_in_valid(valid_b),
        .data_in_ack(ack_b), .serial_out(so_b), .serial_frame(fr_b), .busy(busy_b), .words_sent(ws_b)
    );

    fifo_word_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .COUNT_WIDTH(16)) dut_c (
        .clock(clock), .rst(rst), .enable(en_c), .data_in(data_c), .data_in_valid(valid_c),
        .data_in_ack(ack_c), .serial_out(so_c), .serial_frame(fr_c), .busy(busy_c), .words_sent(ws_c)
    );

    task automatic tick_clk;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        en_a = 0; valid_a = 0; data_a = '0;
        en_b = 0; valid_b = 0; data_b = '0;
        en_c = 0; valid_c = 0; data_c = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick_clk();
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 0;
        #1;
        rst = 1;
        en_a = 1; valid_a = 1; data_a = 8'hFF;
        #1;
        total++; if (fr_a !== 1'b0)   begin bad++; $display("FAIL reset_frame_a got=%b want=0", fr_a); end
        total++; if (so_a !== 1'b0)   begin bad++; $display("FAIL reset_serial_a got=%b want=0", so_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
        total++; if (ack_a !== 1'b0)  begin bad++; $display("FAIL reset_ack_a got=%b want=0", ack_a); end
        total++; if (ws_a !== 16'd0)  begin bad++; $display("FAIL reset_words_a got=%0d want=0", ws_a); end
        total++; if (fr_b !== 1'b0 || so_b !== 1'b0 || ws_b !== 2'd0)
            begin bad++; $display("FAIL reset_b got fr=%b so=%b ws=%0d want 0/0/0", fr_b, so_b, ws_b); end
        total++; if (fr_c !== 1'b0 || so_c !== 1'b0 || ws_c !== 16'd0)
            begin bad++; $display("FAIL reset_c got fr=%b so=%b ws=%0d want 0/0/0", fr_c, so_c, ws_c); end
        tick_clk();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_hold_busy_a got=%b want=0", busy_a); end
        do_reset();
    endtask

    task automatic test_single;
        logic [7:0] word;
        int nack;
        do_reset();
        word = 8'hA5;
        data_a = word; valid_a = 1; en_a = 1;
        #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL single_ack got=%b want=1", ack_a); end
        tick_clk();
        valid_a = 0; data_a = 8'h00;
        nack = 0;
        for (int i = 0; i < 16; i++) begin
            // FIFO contents change under SHIFT and must be ignored
            if (i == 4)  begin valid_a = 1; data_a = 8'h3C; end
            if (i == 12) begin valid_a = 0; data_a = 8'h00; end
            #1;
            if (ack_a === 1'b1) nack++;
            total++; if (fr_a !== 1'b1) begin bad++; $display("FAIL single_frame[%0d] got=%b want=1", i, fr_a); end
            total++; if (so_a !== word[7 - i/2])
                begin bad++; $display("FAIL single_serial[%0d] got=%b want=%b", i, so_a, word[7 - i/2]); end
            tick_clk();
        end
        total++; if (nack !== 0) begin bad++; $display("FAIL single_extra_ack got=%0d want=0", nack); end
        total++; if (fr_a !== 1'b0 || so_a !== 1'b0 || busy_a !== 1'b0)
            begin bad++; $display("FAIL single_end got fr=%b so=%b busy=%b want 0/0/0", fr_a, so_a, busy_a); end
        total++; if (ws_a !== 16'd1) begin bad++; $display("FAIL single_words got=%0d want=1", ws_a); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q [3];
        logic [7:0] cur;
        int ack_cyc [3];
        int nack, idx, pos, started, a;
        logic exp_frame, exp_so;
        q[0] = 8'hFF; q[1] = 8'h00; q[2] = 8'h81;
        do_reset();
        idx = 0; pos = 0; started = 0; nack = 0; cur = '0;
        ack_cyc[0] = 0; ack_cyc[1] = 0; ack_cyc[2] = 0;
        en_a = 1; valid_a = 1; data_a = q[0];
        #1;
        for (int cyc = 0; cyc < 56; cyc++) begin
            a = (ack_a === 1'b1) ? 1 : 0;
            if (a == 1) begin
                if (nack < 3) ack_cyc[nack] = cyc;
                nack++;
            end
            tick_clk();
            if (a == 1 && idx < 3) begin
                cur = q[idx];
                idx++;
                pos = 0;
                started = 1;
                valid_a = (idx < 3);
                data_a  = (idx < 3) ? q[idx] : 8'h5A;
                #1;
            end
            exp_frame = (started == 1) && (pos < 16);
            exp_so    = exp_frame ? cur[7 - pos/2] : 1'b0;
            total++; if (fr_a !== exp_frame)
                begin bad++; $display("FAIL b2b_frame[%0d] got=%b want=%b", cyc, fr_a, exp_frame); end
            total++; if (so_a !== exp_so)
                begin bad++; $display("FAIL b2b_serial[%0d] got=%b want=%b", cyc, so_a, exp_so); end
            if (started == 1) pos++;
        end
        total++; if (nack !== 3) begin bad++; $display("FAIL b2b_ack_count got=%0d want=3", nack); end
        total++; if (ack_cyc[0] !== 0) begin bad++; $display("FAIL b2b_first_ack got=%0d want=0", ack_cyc[0]); end
        total++; if (ack_cyc[1] - ack_cyc[0] !== 17)
            begin bad++; $display("FAIL b2b_gap1 got=%0d want=17", ack_cyc[1] - ack_cyc[0]); end
        total++; if (ack_cyc[2] - ack_cyc[1] !== 17)
            begin bad++; $display("FAIL b2b_gap2 got=%0d want=17", ack_cyc[2] - ack_cyc[1]); end
        total++; if (ws_a !== 16'd3) begin bad++; $display("FAIL b2b_words got=%0d want=3", ws_a); end
        valid_a = 0;
    endtask

    task automatic test_enable_drop;
        logic [7:0] word;
        word = 8'h3C;
        do_reset();
        data_a = word; valid_a = 1; en_a = 1;
        #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL endrop_ack got=%b want=1", ack_a); end
        tick_clk();
        for (int i = 0; i < 16; i++) begin
            if (i == 6) en_a = 0;
            #1;
            total++; if (fr_a !== 1'b1) begin bad++; $display("FAIL endrop_frame[%0d] got=%b want=1", i, fr_a); end
            total++; if (so_a !== word[7 - i/2])
                begin bad++; $display("FAIL endrop_serial[%0d] got=%b want=%b", i, so_a, word[7 - i/2]); end
            total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL endrop_ack_shift[%0d] got=%b want=0", i, ack_a); end
            tick_clk();
        end
        total++; if (ws_a !== 16'd1) begin bad++; $display("FAIL endrop_words got=%0d want=1", ws_a); end
        for (int k = 0; k < 5; k++) begin
            total++; if (ack_a !== 1'b0 || fr_a !== 1'b0 || busy_a !== 1'b0)
                begin bad++; $display("FAIL endrop_hold[%0d] got ack=%b fr=%b busy=%b want 0/0/0", k, ack_a, fr_a, busy_a); end
            tick_clk();
        end
        en_a = 1;
        #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL endrop_resume_ack got=%b want=1", ack_a); end
        tick_clk();
        valid_a = 0;
        total++; if (fr_a !== 1'b1 || busy_a !== 1'b1)
            begin bad++; $display("FAIL endrop_resume_frame got fr=%b busy=%b want 1/1", fr_a, busy_a); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        data_a = 8'hFF; valid_a = 1; en_a = 1;
        tick_clk();
        valid_a = 0;
        for (int i = 0; i < 10; i++) tick_clk();
        total++; if (fr_a !== 1'b1 || so_a !== 1'b1)
            begin bad++; $display("FAIL rstmid_pre got fr=%b so=%b want 1/1", fr_a, so_a); end
        #2;
        rst = 1; valid_a = 1; en_a = 1;
        #1;
        total++; if (fr_a !== 1'b0) begin bad++; $display("FAIL rstmid_frame got=%b want=0", fr_a); end
        total++; if (so_a !== 1'b0) begin bad++; $display("FAIL rstmid_serial got=%b want=0", so_a); end
        total++; if (busy_a !== 1'b0 || ack_a !== 1'b0)
            begin bad++; $display("FAIL rstmid_busy_ack got busy=%b ack=%b want 0/0", busy_a, ack_a); end
        total++; if (ws_a !== 16'd0) begin bad++; $display("FAIL rstmid_words got=%0d want=0", ws_a); end
        tick_clk();
        rst = 0;
        #1;
        total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL rstmid_release_ack got=%b want=1", ack_a); end
        tick_clk();
        valid_a = 0;
        total++; if (fr_a !== 1'b1 || so_a !== 1'b1)
            begin bad++; $display("FAIL rstmid_restart got fr=%b so=%b want 1/1", fr_a, so_a); end
    endtask

    task automatic test_wrap;
        int nack, a;
        do_reset();
        data_b = 8'h11; valid_b = 1; en_b = 1;
        nack = 0;
        #1;
        for (int c = 0; c < 120 && nack < 5; c++) begin
            a = (ack_b === 1'b1) ? 1 : 0;
            tick_clk();
            if (a == 1) begin
                nack++;
                if (nack == 5) valid_b = 0;
            end
        end
        for (int c = 0; c < 40 && busy_b !== 1'b0; c++) tick_clk();
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL wrap_idle_timeout got busy=%b want=0", busy_b); end
        total++; if (nack !== 5) begin bad++; $display("FAIL wrap_acks got=%0d want=5", nack); end
        total++; if (ws_b !== 2'd1) begin bad++; $display("FAIL wrap_words got=%0d want=1", ws_b); end
    endtask

    task automatic test_cpb1;
        logic [7:0] word;
        word = 8'h96;
        do_reset();
        data_c = word; valid_c = 1; en_c = 1;
        #1;
        total++; if (ack_c !== 1'b1) begin bad++; $display("FAIL cpb1_ack got=%b want=1", ack_c); end
        tick_clk();
        valid_c = 0;
        for (int i = 0; i < 8; i++) begin
            total++; if (fr_c !== 1'b1) begin bad++; $display("FAIL cpb1_frame[%0d] got=%b want=1", i, fr_c); end
            total++; if (so_c !== word[7 - i])
                begin bad++; $display("FAIL cpb1_serial[%0d] got=%b want=%b", i, so_c, word[7 - i]); end
            tick_clk();
        end
        total++; if (fr_c !== 1'b0 || busy_c !== 1'b0)
            begin bad++; $display("FAIL cpb1_end got fr=%b busy=%b want 0/0", fr_c, busy_c); end
        total++; if (ws_c !== 16'd1) begin bad++; $display("FAIL cpb1_words got=%0d want=1", ws_c); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        test_cpb1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
